// File: rtl/lif_spike_rate_decoder.sv
// Purpose: count rising edges per spike channel over a programmable window and snapshot the counts.
// Latency: snapshot, sat flags and frame_id update on the window-end edge; frame_valid pulses the next cycle.
// Backpressure: none; ena low freezes all state, clear restarts the current window without a frame.
module lif_spike_rate_decoder #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_CH-1:0]  spike_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             clear,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_sat,
    output logic             frame_valid,
    output logic [7:0]       frame_id
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] LEN_ONE = WIN_W'(1);
    localparam int               N_TAB   = 2 ** SEL_W;

    logic [WIN_W-1:0] timer;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] eff_len;
    logic             win_end;
    logic [N_CH-1:0]  prev;
    logic [N_CH-1:0]  edge_det;

    logic [CNT_W-1:0] live_cnt [N_CH];
    logic [CNT_W-1:0] nxt_cnt  [N_CH];
    logic [CNT_W-1:0] snap_cnt [N_CH];
    logic [N_CH-1:0]  live_sat;
    logic [N_CH-1:0]  nxt_sat;
    logic [N_CH-1:0]  snap_sat;

    logic [CNT_W-1:0] rd_tab [N_TAB];
    logic [N_TAB-1:0] sat_tab;

    // A spike is a 0->1 transition against the previous enabled sample.
    assign edge_det = spike_in & ~prev;

    // Window length comes straight from win_len on the first cycle of a window (0 means 1), else from the latch.
    always_comb begin
        eff_len = (timer == '0) ? win_len : len_q;
        if (eff_len == '0) begin
            eff_len = LEN_ONE;
        end
        win_end = (timer == (eff_len - LEN_ONE));
    end

    // Saturating increment; an edge arriving at full scale is dropped and flagged.
    always_comb begin
        nxt_sat = live_sat;
        for (int i = 0; i < N_CH; i++) begin
            nxt_cnt[i] = live_cnt[i];
            if (edge_det[i]) begin
                if (live_cnt[i] == CNT_MAX) begin
                    nxt_sat[i] = 1'b1;
                end else begin
                    nxt_cnt[i] = live_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Window timer, length latch, edge history and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            len_q       <= '0;
            prev        <= '0;
            frame_id    <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= ena & ~clear & win_end;
            if (ena) begin
                if (clear) begin
                    timer <= '0;
                    prev  <= '0;
                end else begin
                    prev <= spike_in;
                    if (timer == '0) begin
                        len_q <= eff_len;
                    end
                    if (win_end) begin
                        timer    <= '0;
                        frame_id <= frame_id + 8'd1;
                    end else begin
                        timer <= timer + LEN_ONE;
                    end
                end
            end
        end
    end

    // Live counters restart at window end or clear; snapshots capture the closing window including its last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                live_cnt[i] <= '0;
                snap_cnt[i] <= '0;
            end
            live_sat <= '0;
            snap_sat <= '0;
        end else if (ena) begin
            if (clear) begin
                for (int i = 0; i < N_CH; i++) begin
                    live_cnt[i] <= '0;
                end
                live_sat <= '0;
            end else if (win_end) begin
                for (int i = 0; i < N_CH; i++) begin
                    snap_cnt[i] <= nxt_cnt[i];
                    live_cnt[i] <= '0;
                end
                snap_sat <= nxt_sat;
                live_sat <= '0;
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    live_cnt[i] <= nxt_cnt[i];
                end
                live_sat <= nxt_sat;
            end
        end
    end

    // Readout table padded to a power of two so unused selects read as zero.
    for (genvar g = 0; g < N_TAB; g++) begin : g_rd
        if (g < N_CH) begin : g_ch
            assign rd_tab[g]  = snap_cnt[g];
            assign sat_tab[g] = snap_sat[g];
        end else begin : g_pad
            assign rd_tab[g]  = '0;
            assign sat_tab[g] = 1'b0;
        end
    end

    assign rd_count = rd_tab[rd_sel];
    assign rd_sat   = sat_tab[rd_sel];

endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
module tb_lif_spike_rate_decoder;

    localparam int N_CH    = 8;
    localparam int CNT_W   = 8;
    localparam int WIN_W   = 16;
    localparam int SEL_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic [N_CH-1:0]  spike_in = '0;
    logic [WIN_W-1:0] win_len = '0;
    logic             clear = 1'b0;
    logic [SEL_W-1:0] rd_sel = '0;
    logic [CNT_W-1:0] rd_count;
    logic             rd_sat;
    logic             frame_valid;
    logic [7:0]       frame_id;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain edge tallies per window, clipped only when the frame is reported.
    int              m_cnt  [N_CH];
    int              m_snap [N_CH];
    bit              m_ssat [N_CH];
    logic [N_CH-1:0] m_prev;
    int              m_pos;
    int              m_len;
    int              m_fid;
    bit              m_fv;

    // Directed expectation checked at the next sampling point.
    bit dir_en = 0;
    int dir_ch, dir_cnt, dir_sat, dir_fid, dir_fv;

    lif_spike_rate_decoder #(
        .N_CH (N_CH),
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .clear      (clear),
        .rd_sel     (rd_sel),
        .rd_count   (rd_count),
        .rd_sat     (rd_sat),
        .frame_valid(frame_valid),
        .frame_id   (frame_id)
    );

    always #10 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
            m_ssat[i] = 0;
        end
        m_prev = '0;
        m_pos  = 0;
        m_len  = 1;
        m_fid  = 0;
        m_fv   = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        m_fv = 0;
        if (ena) begin
            if (clear) begin
                for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
                m_prev = '0;
                m_pos  = 0;
            end else begin
                if (m_pos == 0) m_len = (win_len == 0) ? 1 : int'(win_len);
                for (int i = 0; i < N_CH; i++)
                    if (spike_in[i] && !m_prev[i]) m_cnt[i]++;
                m_prev = spike_in;
                if (m_pos == m_len - 1) begin
                    for (int i = 0; i < N_CH; i++) begin
                        m_snap[i] = (m_cnt[i] > CNT_MAX) ? CNT_MAX : m_cnt[i];
                        m_ssat[i] = (m_cnt[i] > CNT_MAX);
                        m_cnt[i]  = 0;
                    end
                    m_fid = (m_fid + 1) % 256;
                    m_fv  = 1;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk_eq("frame_valid", frame_valid, m_fv);
        chk_eq("frame_id", frame_id, m_fid);
        chk_eq("rd_count", rd_count, m_snap[rd_sel]);
        chk_eq("rd_sat", rd_sat, m_ssat[rd_sel]);
        if (m_fv) begin
            for (int j = 0; j < N_CH; j++) begin
                rd_sel = SEL_W'(j);
                #1;
                chk_eq("snap_count", rd_count, m_snap[j]);
                chk_eq("snap_sat", rd_sat, m_ssat[j]);
            end
        end
        if (dir_en) begin
            rd_sel = SEL_W'(dir_ch);
            #1;
            chk_eq("dir_count", rd_count, dir_cnt);
            chk_eq("dir_sat", rd_sat, dir_sat);
            chk_eq("dir_frame_id", frame_id, dir_fid);
            chk_eq("dir_frame_valid", frame_valid, dir_fv);
            dir_en = 0;
        end
    endtask

    task automatic set_dir(input int ch, input int cnt, input int sat, input int fid, input int fv);
        dir_en  = 1;
        dir_ch  = ch;
        dir_cnt = cnt;
        dir_sat = sat;
        dir_fid = fid;
        dir_fv  = fv;
    endtask

    // Check the previous clock's results, then apply inputs for the next one.
    task automatic cycle(input bit e, input bit c, input logic [N_CH-1:0] s, input int wl);
        @(negedge clk);
        check_outputs();
        ena      = e;
        clear    = c;
        spike_in = s;
        win_len  = WIN_W'(wl);
        rd_sel   = SEL_W'($urandom_range(N_CH - 1));
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        ena      = 1'b0;
        clear    = 1'b0;
        spike_in = '0;
        model_reset();
        for (int j = 0; j < N_CH; j++) begin
            rd_sel = SEL_W'(j);
            #1;
            chk_eq("rst_count", rd_count, 0);
            chk_eq("rst_sat", rd_sat, 0);
        end
        chk_eq("rst_frame_valid", frame_valid, 0);
        chk_eq("rst_frame_id", frame_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Channel 0 pulsed every other cycle through a 10-cycle window.
        for (int k = 0; k < 10; k++) cycle(1, 0, (k % 2 == 0) ? 8'h01 : 8'h00, 10);
        set_dir(0, 5, 0, 1, 1);

        // Channel 3 held high across two windows: one edge, then none.
        for (int k = 0; k < 10; k++) cycle(1, 0, 8'h08, 10);
        set_dir(3, 1, 0, 2, 1);
        for (int k = 0; k < 10; k++) cycle(1, 0, 8'h08, 10);
        set_dir(3, 0, 0, 3, 1);

        // Edge on the window-end cycle vs. edge on the first cycle of the next window.
        for (int k = 0; k < 8; k++) begin
            if (k == 4) set_dir(1, 1, 0, 4, 1);
            cycle(1, 0, ((k == 3) ? 8'h02 : 8'h00) | ((k == 4) ? 8'h04 : 8'h00), 4);
        end
        set_dir(2, 1, 0, 5, 1);

        // Saturation: 500 edges in a 1000-cycle window, then 3 edges.
        for (int k = 0; k < 1000; k++) cycle(1, 0, (k % 2 == 0) ? 8'h80 : 8'h00, 1000);
        set_dir(7, 255, 1, 6, 1);
        for (int k = 0; k < 1000; k++) cycle(1, 0, (k < 6 && k % 2 == 0) ? 8'h80 : 8'h00, 1000);
        set_dir(7, 3, 0, 7, 1);

        // ena low for 5 cycles mid-window; edges offered then must be ignored.
        for (int k = 0; k < 13; k++)
            cycle(!(k >= 3 && k <= 7), 0, (k == 4 || k == 6) ? 8'h20 : 8'h00, 8);
        set_dir(5, 0, 0, 8, 1);

        // clear on the window-end cycle: no frame, snapshot and frame_id kept.
        for (int k = 0; k < 5; k++) cycle(1, (k == 4), (k == 1) ? 8'h01 : 8'h00, 5);
        set_dir(5, 0, 0, 8, 0);
        for (int k = 0; k < 5; k++) cycle(1, 0, (k == 2) ? 8'h01 : 8'h00, 5);
        set_dir(0, 1, 0, 9, 1);

        // Random traffic: short windows, sporadic stalls and clears.
        for (int k = 0; k < 3000; k++)
            cycle($urandom_range(99) < 85, $urandom_range(99) < 3,
                  N_CH'($urandom), $urandom_range(6));

        // Reset in the middle of a window discards it.
        for (int k = 0; k < 3; k++) cycle(1, 0, N_CH'($urandom), 7);
        do_reset();
        for (int k = 0; k < 500; k++)
            cycle($urandom_range(99) < 90, $urandom_range(99) < 2,
                  N_CH'($urandom), $urandom_range(9));
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
